// File: rtl/apu_frame_counter.sv
// APU frame counter: divides ACLK1 ticks into quarter/half-frame strobes (nLFO1/nLFO2) in 4-step or
// 5-step mode programmed by $4017. Define FRAME_IRQ_EN to build the frame interrupt flag and n_IRQ.
module apu_frame_counter #(
  parameter int STEP_PERIOD = 3728,
  parameter int CNT_W       = 15
) (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       ACLK1,
  input  logic       W4017,
  input  logic [7:0] DB,
  input  logic       n_R4015,
  output logic       nLFO1,
  output logic       nLFO2,
  output logic       INT_FF,
  output logic       n_IRQ
);

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

  localparam logic [CNT_W-1:0] STEP1 = CNT_W'(1 * STEP_PERIOD);
  localparam logic [CNT_W-1:0] STEP2 = CNT_W'(2 * STEP_PERIOD);
  localparam logic [CNT_W-1:0] STEP3 = CNT_W'(3 * STEP_PERIOD);
  localparam logic [CNT_W-1:0] STEP4 = CNT_W'(4 * STEP_PERIOD);
  localparam logic [CNT_W-1:0] STEP5 = CNT_W'(5 * STEP_PERIOD);

  seq_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pend_q, pend_d;
  logic             lfo1_n_q, lfo1_n_d;
  logic             lfo2_n_q, lfo2_n_d;
  logic [4:0]       step_hit;
  logic             quarter, half, frame_end;
  logic             frame_irq_set;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    cnt_inc       = cnt_q + CNT_W'(1);
    step_hit      = {cnt_inc == STEP5, cnt_inc == STEP4, cnt_inc == STEP3,
                     cnt_inc == STEP2, cnt_inc == STEP1};
    quarter       = 1'b0;
    half          = 1'b0;
    frame_end     = 1'b0;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    mode_d        = mode_q;
    lfo1_n_d      = lfo1_n_q;
    lfo2_n_d      = lfo2_n_q;
    frame_irq_set = 1'b0;

    if (mode_q == MODE_4STEP) begin
      quarter   = |step_hit[3:0];
      half      = step_hit[1] | step_hit[3];
      frame_end = step_hit[3];
    end else begin
      quarter   = (|step_hit[2:0]) | step_hit[4];
      half      = step_hit[1] | step_hit[4];
      frame_end = step_hit[4];
    end

    // Strobes are held from one tick to the next, so they only change on a tick.
    if (ACLK1) begin
      lfo1_n_d = 1'b1;
      lfo2_n_d = 1'b1;
      if (pend_q) begin
        // A pending restart takes this tick outright; any step due now is dropped.
        cnt_d  = '0;
        pend_d = 1'b0;
        if (mode_q == MODE_5STEP) begin
          lfo1_n_d = 1'b0;
          lfo2_n_d = 1'b0;
        end
      end else begin
        cnt_d    = frame_end ? '0 : cnt_inc;
        lfo1_n_d = ~quarter;
        lfo2_n_d = ~half;
        frame_irq_set = frame_end && (mode_q == MODE_4STEP);
      end
    end

    // A write landing on a tick edge is only latched; its restart waits for the next tick.
    if (W4017) begin
      mode_d = seq_mode_e'(DB[7]);
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values and simulation order cannot change the result.
    if (!n_RES) begin
      cnt_q    <= '0;
      mode_q   <= MODE_4STEP;
      pend_q   <= 1'b0;
      lfo1_n_q <= 1'b1;
      lfo2_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      lfo1_n_q <= lfo1_n_d;
      lfo2_n_q <= lfo2_n_d;
    end
  end

  assign nLFO1 = lfo1_n_q;
  assign nLFO2 = lfo2_n_q;

`ifdef FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic int_q, int_d;

  always_comb begin
    inhibit_d = W4017 ? DB[6] : inhibit_q;
    int_d     = int_q;
    if (!n_R4015 || (W4017 && DB[6])) begin
      int_d = 1'b0;
    end
    // Setting the flag beats any clear on the same edge.
    if (frame_irq_set && !inhibit_q) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      inhibit_q <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      int_q     <= int_d;
    end
  end

  assign INT_FF = int_q;
  assign n_IRQ  = ~(int_q & ~inhibit_q);

  logic unused_db;
  assign unused_db = ^DB[5:0];
`else
  assign INT_FF = 1'b0;
  assign n_IRQ  = 1'b1;

  logic unused_irq;
  assign unused_irq = ^{DB[6:0], n_R4015, frame_irq_set};
`endif

endmodule
